ram_burst_reader: RTL and testbench

//  Read-side master for the dual-port RAM (sync write port, registered read port).
//  On START it streams LENGTH consecutive words from BASE_ADDR out of the RAM read

---
 rtl/ram_burst_reader_pkg.sv | 15 +
 rtl/ram_burst_reader_if.sv | 25 ++
 rtl/ram_rd_fifo.sv | 47 ++++
 rtl/ram_burst_reader.sv | 121 ++++++++++++
 tb/tb_ram_burst_reader.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ram_burst_reader_pkg.sv
// rtl/ram_burst_reader_pkg.sv - shared defaults and FSM state type for the RAM burst reader
package ram_pkg;

    localparam int ADDR_WIDTH = 10;
    localparam int DATA_WIDTH = 32;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } rd_state_t;

endpackage

// File: rtl/ram_burst_reader_if.sv
// rtl/ram_burst_reader_if.sv - valid/ready output stream carrying burst words
interface ram_burst_reader_if #(
    parameter int data_width = ram_pkg::DATA_WIDTH
) ();

    logic [data_width-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/ram_rd_fifo.sv
// rtl/ram_rd_fifo.sv - small synchronous FIFO with same-cycle push and pop
module ram_rd_fifo #(
    parameter int width = 33,
    parameter int depth = 4,
    localparam int cw = $clog2(depth + 1),
    localparam int pw = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] head,
    output logic [cw-1:0]    count
);

    logic [width-1:0] mem [depth];
    logic [pw-1:0]    wr_ptr;
    logic [pw-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && (count != cw'(depth));
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == pw'(depth - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == pw'(depth - 1)) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + cw'(do_push) - cw'(do_pop);
        end
    end

endmodule

// File: rtl/ram_burst_reader.sv
// rtl/ram_burst_reader.sv - streams a block of consecutive RAM words onto a valid/ready stream
module ram_burst_reader
    import ram_pkg::*;
#(
    parameter int addr_width = ADDR_WIDTH,
    parameter int data_width = DATA_WIDTH,
    parameter int fifo_depth = FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [addr_width-1:0] base_addr,
    input  logic [addr_width:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [addr_width-1:0] addr_r,
    input  logic [data_width-1:0] q_r,
    ram_burst_reader_if.master    strm
);

    localparam int cw = $clog2(fifo_depth + 1);
    localparam logic [addr_width:0] len_one = 1;

    rd_state_t             state;
    rd_state_t             state_nxt;
    logic [addr_width:0]   remaining;
    logic                  p1, p2;
    logic                  l1, l2;
    logic [data_width:0]   fifo_head;
    logic [cw-1:0]         fifo_count;
    logic                  pop;
    logic                  start_ok;
    logic                  run_issue;
    logic [cw+1:0]         credit_sum;

    assign start_ok = start && (state == IDLE || state == FIN);
    assign pop      = strm.out_valid && strm.out_ready;

    // Reads in flight (p1: address presented, p2: RAM data on q_r) hold FIFO slots in advance.
    assign credit_sum = (cw+2)'(fifo_count) + (cw+2)'(p1) + (cw+2)'(p2) - (cw+2)'(pop);
    assign run_issue  = (state == RUN) && (remaining != '0) && (credit_sum < (cw+2)'(fifo_depth));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FIN: begin
                state_nxt = IDLE;
                if (start_ok) begin
                    state_nxt = (length == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (remaining == '0 || (run_issue && remaining == len_one)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && fifo_head[data_width]) begin
                    state_nxt = FIN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_r    <= '0;
            remaining <= '0;
            p1        <= 1'b0;
            p2        <= 1'b0;
            l1        <= 1'b0;
            l2        <= 1'b0;
        end else begin
            if (start_ok) begin
                addr_r    <= base_addr;
                remaining <= (length == '0) ? '0 : length - len_one;
                p1        <= (length != '0);
                l1        <= (length == len_one);
            end else if (run_issue) begin
                addr_r    <= addr_r + 1'b1;
                remaining <= remaining - len_one;
                p1        <= 1'b1;
                l1        <= (remaining == len_one);
            end else begin
                p1 <= 1'b0;
                l1 <= 1'b0;
            end
            p2 <= p1;
            l2 <= l1;
        end
    end

    ram_rd_fifo #(
        .width (data_width + 1),
        .depth (fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .resetn    (reset_n),
        .push      (p2),
        .push_data ({l2, q_r}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign strm.out_valid = (fifo_count != '0);
    assign strm.out_data  = fifo_head[data_width-1:0];
    assign strm.out_last  = strm.out_valid && fifo_head[data_width];
    assign busy           = (state == RUN) || (state == DRAIN);
    assign done           = (state == FIN);

endmodule

// File: tb/tb_ram_burst_reader.sv
// tb/tb_ram_burst_reader.sv - scoreboard bench for ram_burst_reader against a preloaded RAM model
module tb_ram_burst_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic        busy;
    logic        done;
    logic [9:0]  addr_r;
    logic [31:0] q_r;

    always #5 clk = ~clk;

    ram_burst_reader_if strm ();

    ram_burst_reader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .addr_r    (addr_r),
        .q_r       (q_r),
        .strm      (strm)
    );

    logic [31:0] ram [1024];
    always @(posedge clk) q_r <= ram[addr_r];

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          hs_count = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] held_data;
    logic        held_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Monitor: compares every handshaken word against the scoreboard head.
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid_held", 32'(strm.out_valid), 32'd1);
                chk("stall_data_stable", strm.out_data, held_data);
                chk("stall_last_stable", 32'(strm.out_last), 32'(held_last));
            end
            if (strm.out_valid && strm.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got %h required no word", strm.out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("word_data", strm.out_data, e.data);
                    chk("word_last", 32'(strm.out_last), 32'(e.last));
                end
                hs_count++;
            end
            stall_prev = strm.out_valid && !strm.out_ready;
            held_data  = strm.out_data;
            held_last  = strm.out_last;
        end
    end

    task automatic launch(input logic [9:0] b, input logic [10:0] n);
        for (int i = 0; i < int'(n); i++) begin
            exp_t e;
            e.last = (i == int'(n) - 1);
            e.data = 32'hA000_0000 + 32'((int'(b) + i) % 1024);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b1; base_addr = b; length = n;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < limit && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'hA000_0000 + 32'(i);
        reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
        strm.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(strm.out_valid), 32'd0);
        chk("rst_addr", 32'(addr_r), 32'd0);
        chk("rst_data", strm.out_data, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Basic burst, consumer always ready
        launch(10'd5, 11'd4);
        @(negedge clk);
        chk("basic_addr0", 32'(addr_r), 32'd5);
        chk("basic_busy", 32'(busy), 32'd1);
        chk("basic_valid_lat0", 32'(strm.out_valid), 32'd0);
        @(negedge clk);
        chk("basic_valid_lat1", 32'(strm.out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("basic_valid", 32'(strm.out_valid), 32'd1);
            chk("basic_last", 32'(strm.out_last), 32'(i == 3));
        end
        @(negedge clk);
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_valid_end", 32'(strm.out_valid), 32'd0);
        @(negedge clk);
        chk("basic_done_pulse", 32'(done), 32'd0);
        chk("basic_idle", 32'(busy), 32'd0);

        // Backpressure with a stray START while busy
        launch(10'd0, 11'd8);
        begin
            logic seen;
            seen = 1'b0;
            for (int c = 0; c < 100 && !seen; c++) begin
                @(posedge clk);
                #1;
                strm.out_ready = (c >= 6 && c <= 10) ? 1'b0 : (c % 2 == 0);
                start = (c == 3);
                base_addr = 10'd100;
                length = 11'd3;
                @(negedge clk);
                if (done) seen = 1'b1;
            end
            chk("bp_done", 32'(seen), 32'd1);
        end
        @(posedge clk);
        #1 strm.out_ready = 1'b1; start = 1'b0;
        chk("bp_all_words", 32'(exp_q.size()), 32'd0);

        // Address wrap
        launch(10'd1022, 11'd4);
        @(negedge clk); chk("wrap_addr0", 32'(addr_r), 32'd1022);
        @(negedge clk); chk("wrap_addr1", 32'(addr_r), 32'd1023);
        @(negedge clk); chk("wrap_addr2", 32'(addr_r), 32'd0);
        @(negedge clk); chk("wrap_addr3", 32'(addr_r), 32'd1);
        wait_done(20, "wrap_done");
        chk("wrap_all_words", 32'(exp_q.size()), 32'd0);

        // Zero length
        launch(10'd7, 11'd0);
        @(negedge clk);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("zero_done_pulse", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("zero_no_valid", 32'(strm.out_valid), 32'd0);
        end

        // Reset in the middle of a burst
        launch(10'd100, 11'd16);
        begin
            int target;
            target = hs_count + 3;
            for (int c = 0; c < 50 && hs_count < target; c++) @(posedge clk);
            chk("midrst_hs_reached", 32'(hs_count >= target), 32'd1);
        end
        #1 reset_n = 1'b0; strm.out_ready = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 reset_n = 1'b1; strm.out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(strm.out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_last", 32'(strm.out_last), 32'd0);
        chk("midrst_data", strm.out_data, 32'd0);
        launch(10'd20, 11'd2);
        wait_done(20, "midrst_new_done");
        repeat (4) @(negedge clk);
        chk("midrst_all_words", 32'(exp_q.size()), 32'd0);

        // Whole-memory burst
        begin
            int hs0;
            hs0 = hs_count;
            launch(10'd512, 11'd1024);
            wait_done(1200, "full_done");
            chk("full_word_count", 32'(hs_count - hs0), 32'd1024);
            chk("full_all_words", 32'(exp_q.size()), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
